// File: rtl/pu_buffer_fifo_pkg.sv
// Shared sizing helpers for the PU buffer FIFO and the SPI master/slave PUs that
// reuse the same depth arithmetic.
//   addr_width(n) : bits needed to address n words (n >= 2)
//   cnt_width(n)  : bits needed to hold an occupancy of 0..n
package pu_buffer_fifo_pkg;

  function automatic int addr_width(input int n);
    return $clog2(n);
  endfunction

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/pu_buffer_fifo_ptr.sv
// Wrapping circular-buffer pointer. Counts 0..BUF_SIZE-1 and wraps explicitly,
// so non-power-of-two depths never alias.
//   clk  : system clock
//   rst  : synchronous active-high reset, pointer -> 0
//   clr  : synchronous flush, pointer -> 0
//   inc  : advance by one this cycle
//   ptr  : current pointer value
module pu_buffer_ptr #(
  parameter int ADDR_WIDTH = 3,
  parameter int BUF_SIZE   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  inc,
  output logic [ADDR_WIDTH-1:0] ptr
);

  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(BUF_SIZE - 1);

  logic [ADDR_WIDTH-1:0] ptr_d, ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = (ptr_q == LAST) ? '0 : ptr_q + ADDR_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/pu_buffer_fifo.sv
// Circular FIFO between SPI shift logic and the PU transfer side. Strobes are
// levels; a word is committed on the falling edge of its strobe.
//   clk        : system clock
//   rst        : synchronous active-high reset
//   clr        : synchronous flush (memory and data_out keep their values)
//   wr/data_in : write strobe and data; data staged every cycle wr=1
//   oe         : read strobe; data_out reloaded every cycle oe=1 and not empty
//   data_out   : registered read data
//   full/empty : registered occupancy flags
//   count      : occupancy 0..BUF_SIZE
//   overflow   : sticky, a push was rejected
//   underflow  : sticky, a pop was rejected
module pu_buffer_fifo
  import pu_buffer_fifo_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int BUF_SIZE   = 8,
  localparam int ADDR_WIDTH = addr_width(BUF_SIZE),
  localparam int CNT_WIDTH  = cnt_width(BUF_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  oe,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(BUF_SIZE);

  logic [DATA_WIDTH-1:0] mem [BUF_SIZE];

  logic [DATA_WIDTH-1:0] stage_d, stage_q;
  logic [DATA_WIDTH-1:0] dout_d, dout_q;
  logic                  wr_dly_d, wr_dly_q, oe_dly_d, oe_dly_q;
  logic                  wr_blk_d, wr_blk_q, oe_blk_d, oe_blk_q;
  logic [CNT_WIDTH-1:0]  count_d, count_q;
  logic                  full_d, full_q, empty_d, empty_q;
  logic                  ovf_d, ovf_q, udf_d, udf_q;

  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic                  push, pop, push_ok, pop_ok;

  always_comb begin
    // rst and clr both discard whatever strobe edge is pending this cycle.
    push    = wr_dly_q & ~wr & ~clr & ~rst;
    pop     = oe_dly_q & ~oe & ~clr & ~rst;
    // A same-cycle push cannot rescue a pop on empty, but a pop frees room for a push.
    pop_ok  = pop & ~empty_q;
    push_ok = push & (~full_q | pop_ok);

    stage_d  = wr ? data_in : stage_q;
    dout_d   = (oe & ~empty_q) ? mem[rd_ptr] : dout_q;

    // A strobe that is high while clr is asserted stays blocked until it drops,
    // so holding it across the flush never produces an edge-reg set / commit.
    wr_blk_d = wr_blk_q & wr;
    oe_blk_d = oe_blk_q & oe;
    wr_dly_d = wr & ~wr_blk_q;
    oe_dly_d = oe & ~oe_blk_q;

    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_WIDTH'(1);
      2'b01:   count_d = count_q - CNT_WIDTH'(1);
      default: count_d = count_q;
    endcase

    ovf_d = ovf_q | (push & ~push_ok);
    udf_d = udf_q | (pop & ~pop_ok);

    if (clr) begin
      stage_d  = '0;
      dout_d   = dout_q;
      wr_blk_d = wr;
      oe_blk_d = oe;
      wr_dly_d = 1'b0;
      oe_dly_d = 1'b0;
      count_d  = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end

    full_d  = (count_d == CNT_MAX);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q  <= '0;
      dout_q   <= '0;
      wr_dly_q <= 1'b0;
      oe_dly_q <= 1'b0;
      wr_blk_q <= wr;
      oe_blk_q <= oe;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      stage_q  <= stage_d;
      dout_q   <= dout_d;
      wr_dly_q <= wr_dly_d;
      oe_dly_q <= oe_dly_d;
      wr_blk_q <= wr_blk_d;
      oe_blk_q <= oe_blk_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage array: no reset, written only by an accepted push.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= stage_q;
    end
  end

  pu_buffer_ptr #(.ADDR_WIDTH(ADDR_WIDTH), .BUF_SIZE(BUF_SIZE)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (push_ok),
    .ptr (wr_ptr)
  );

  pu_buffer_ptr #(.ADDR_WIDTH(ADDR_WIDTH), .BUF_SIZE(BUF_SIZE)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .inc (pop_ok),
    .ptr (rd_ptr)
  );

  assign data_out  = dout_q;
  assign full      = full_q;
  assign empty     = empty_q;
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = udf_q;

endmodule

// File: tb/tb_pu_buffer_fifo.sv
module tb_pu_buffer_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] clr, wr, oe;
  logic [7:0] di [2];

  logic [7:0] do8, do5;
  logic       full8, empty8, ovf8, udf8;
  logic       full5, empty5, ovf5, udf5;
  logic [3:0] count8;
  logic [2:0] count5;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pu_buffer_fifo #(.DATA_WIDTH(8), .BUF_SIZE(8)) dut8 (
    .clk(clk), .rst(rst), .clr(clr[0]), .wr(wr[0]), .data_in(di[0]), .oe(oe[0]),
    .data_out(do8), .full(full8), .empty(empty8), .count(count8),
    .overflow(ovf8), .underflow(udf8)
  );

  pu_buffer_fifo #(.DATA_WIDTH(8), .BUF_SIZE(5)) dut5 (
    .clk(clk), .rst(rst), .clr(clr[1]), .wr(wr[1]), .data_in(di[1]), .oe(oe[1]),
    .data_out(do5), .full(full5), .empty(empty5), .count(count5),
    .overflow(ovf5), .underflow(udf5)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // All stimulus tasks start and end on a falling edge.
  task automatic push(input int u, input logic [7:0] d, input int hi);
    wr[u] = 1'b1;
    di[u] = d;
    repeat (hi) @(negedge clk);
    wr[u] = 1'b0;
    @(negedge clk);
  endtask

  task automatic pop(input int u, input int hi);
    oe[u] = 1'b1;
    repeat (hi) @(negedge clk);
    oe[u] = 1'b0;
    @(negedge clk);
  endtask

  task automatic push_pop(input int u, input logic [7:0] d, input int hi);
    wr[u] = 1'b1;
    oe[u] = 1'b1;
    di[u] = d;
    repeat (hi) @(negedge clk);
    wr[u] = 1'b0;
    oe[u] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; clr = '0; wr = '0; oe = '0; di[0] = '0; di[1] = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst_empty", empty8, 1);
    chk("rst_full", full8, 0);
    chk("rst_count", count8, 0);
    chk("rst_dout", do8, 0);
    chk("rst_ovf", ovf8, 0);
    chk("rst_udf", udf8, 0);

    // Fill with 2-cycle write pulses.
    for (int i = 1; i <= 8; i++) push(0, 8'(i * 8'h11), 2);
    chk("fill_full", full8, 1);
    chk("fill_count", count8, 8);
    chk("fill_empty", empty8, 0);

    // Simultaneous commit while full: old head read, new word stored at tail.
    push_pop(0, 8'hAB, 2);
    chk("sim_dout", do8, 8'h11);
    chk("sim_count", count8, 8);
    chk("sim_full", full8, 1);
    chk("sim_ovf", ovf8, 0);

    // Push into full FIFO is rejected.
    push(0, 8'h99, 2);
    chk("ovf_flag", ovf8, 1);
    chk("ovf_count", count8, 8);

    // Drain with 3-cycle read pulses.
    for (int i = 2; i <= 8; i++) begin
      pop(0, 3);
      chk($sformatf("drain_%0d", i), do8, 32'(i * 8'h11));
    end
    pop(0, 3);
    chk("drain_new", do8, 8'hAB);
    chk("drain_empty", empty8, 1);
    chk("drain_count", count8, 0);
    chk("drain_full", full8, 0);

    // Pop on empty is rejected, data_out holds.
    pop(0, 3);
    chk("udf_flag", udf8, 1);
    chk("udf_dout", do8, 8'hAB);
    chk("udf_count", count8, 0);

    // Flush while a write strobe is held.
    push(0, 8'h5A, 2);
    chk("pre_clr_count", count8, 1);
    wr[0] = 1'b1; di[0] = 8'h77;
    @(negedge clk);
    clr[0] = 1'b1;
    @(negedge clk);
    clr[0] = 1'b0;
    repeat (2) @(negedge clk);
    wr[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("clr_count", count8, 0);
    chk("clr_empty", empty8, 1);
    chk("clr_udf", udf8, 0);
    chk("clr_ovf", ovf8, 0);
    chk("clr_dout", do8, 8'hAB);

    // FIFO still works after the flush.
    push(0, 8'h3C, 2);
    pop(0, 3);
    chk("post_clr_dout", do8, 8'h3C);
    chk("post_clr_count", count8, 0);

    // Reset while a write strobe is held.
    wr[0] = 1'b1; di[0] = 8'h66;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    wr[0] = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_hold_count", count8, 0);
    chk("rst_hold_empty", empty8, 1);
    chk("rst_hold_dout", do8, 0);

    // Wrap on a non-power-of-two depth.
    for (int i = 1; i <= 3; i++) push(1, 8'(i), 2);
    for (int i = 1; i <= 3; i++) begin
      pop(1, 3);
      chk($sformatf("w5_pre_%0d", i), do5, 32'(i));
    end
    for (int i = 0; i < 5; i++) push(1, 8'(8'hA0 + i), 2);
    chk("w5_full", full5, 1);
    chk("w5_count_full", count5, 5);
    chk("w5_ovf", ovf5, 0);
    for (int i = 0; i < 5; i++) begin
      pop(1, 3);
      chk($sformatf("w5_rd_%0d", i), do5, 32'(8'hA0 + i));
    end
    chk("w5_count", count5, 0);
    chk("w5_empty", empty5, 1);
    chk("w5_udf", udf5, 0);
    chk("w5_wr_ptr", dut5.wr_ptr, 3);
    chk("w5_rd_ptr", dut5.rd_ptr, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
